// File: rtl/dmem_req_ctrl.sv
// rtl/dmem_req_ctrl.sv - data memory request controller between EX/MEM and the data memory
//
// Accepts one load/store from EX/MEM at a time, drives a single-cycle strobe to the
// data memory, waits for completion (memDone), error (memErr) or a WAIT-state timeout,
// then reports a one-cycle response. Counts cache hits and misses with saturation.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   exValid/exMemRead/
//   exMemWrite/exAddr/
//   exWriteData              request from EX/MEM
//   memDataOut/memDone/
//   memStall/memCacheHit/
//   memErr                   status and read data from data memory
//   memAddr/memDataIn/
//   memRd/memWr              request to data memory
//   stallPipe                freeze upstream pipeline while an access is in flight
//   readData/respValid/
//   errOut                   response to MEM/WB
//   hitCount/missCount       saturating statistics counters
module dmem_req_ctrl #(
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exValid,
  input  logic        exMemRead,
  input  logic        exMemWrite,
  input  logic [15:0] exAddr,
  input  logic [15:0] exWriteData,
  input  logic [15:0] memDataOut,
  input  logic        memDone,
  input  logic        memStall,
  input  logic        memCacheHit,
  input  logic        memErr,
  output logic [15:0] memAddr,
  output logic [15:0] memDataIn,
  output logic        memRd,
  output logic        memWr,
  output logic        stallPipe,
  output logic [15:0] readData,
  output logic        respValid,
  output logic        errOut,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          is_wr_q, is_wr_d;
  logic          err_q, err_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   hit_count_q, hit_count_d;
  logic [15:0]   miss_count_q, miss_count_d;
  logic [CW-1:0] wcnt_q, wcnt_d;

  logic accept;
  logic in_access;
  logic timeout;

  // Busy indication from memory carries no decision weight here.
  logic unused_mem_stall;
  assign unused_mem_stall = memStall;

  assign accept    = ((state_q == S_IDLE) || (state_q == S_RESP)) &&
                     exValid && (exMemRead || exMemWrite);
  assign in_access = (state_q == S_REQ) || (state_q == S_WAIT);
  // Counter starts at 0 on the first WAIT cycle, so TIMEOUT-1 marks the last allowed one.
  assign timeout   = (state_q == S_WAIT) && (wcnt_q == CW'(TIMEOUT - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_wr_q      <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_wr_q      <= is_wr_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wcnt_q       <= wcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) state_d = exAddr[0] ? S_RESP : S_REQ;
        else        state_d = S_IDLE;
      end
      S_REQ: begin
        if (memErr || memDone) state_d = S_RESP;
        else                   state_d = S_WAIT;
      end
      S_WAIT: begin
        if (memErr || memDone || timeout) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-values
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_wr_d      = is_wr_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wcnt_d       = wcnt_q;

    if (accept) begin
      addr_d  = exAddr;
      wdata_d = exWriteData;
      is_wr_d = exMemWrite;      // read+write together counts as a write
      err_d   = exAddr[0];
      if (exAddr[0]) rdata_d = '0;
    end

    if (state_q == S_REQ) wcnt_d = '0;
    else if (state_q == S_WAIT) wcnt_d = wcnt_q + CW'(1);

    if (in_access) begin
      if (memErr) begin
        err_d = 1'b1;
      end else if (memDone) begin
        err_d = 1'b0;
        if (!is_wr_q) rdata_d = memDataOut;
        // Only a completion in the REQ cycle can be a hit; anything that waited is a miss.
        if ((state_q == S_REQ) && memCacheHit) begin
          if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
        end else begin
          if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
        end
      end else if (timeout) begin
        err_d = 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    memRd     = (state_q == S_REQ) && !is_wr_q;
    memWr     = (state_q == S_REQ) && is_wr_q;
    stallPipe = in_access;
    respValid = (state_q == S_RESP);
    errOut    = (state_q == S_RESP) && err_q;
    memAddr   = addr_q;
    memDataIn = wdata_q;
    readData  = rdata_q;
    hitCount  = hit_count_q;
    missCount = miss_count_q;
  end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb/tb_dmem_req_ctrl.sv - self-checking bench for dmem_req_ctrl
module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exValid = 1'b0;
  logic        exMemRead = 1'b0;
  logic        exMemWrite = 1'b0;
  logic [15:0] exAddr = '0;
  logic [15:0] exWriteData = '0;
  logic [15:0] memDataOut = '0;
  logic        memDone = 1'b0;
  logic        memStall = 1'b0;
  logic        memCacheHit = 1'b0;
  logic        memErr = 1'b0;
  logic [15:0] memAddr;
  logic [15:0] memDataIn;
  logic        memRd;
  logic        memWr;
  logic        stallPipe;
  logic [15:0] readData;
  logic        respValid;
  logic        errOut;
  logic [15:0] hitCount;
  logic [15:0] missCount;

  dmem_req_ctrl #(.TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .exValid(exValid), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exAddr(exAddr), .exWriteData(exWriteData),
    .memDataOut(memDataOut), .memDone(memDone), .memStall(memStall),
    .memCacheHit(memCacheHit), .memErr(memErr),
    .memAddr(memAddr), .memDataIn(memDataIn), .memRd(memRd), .memWr(memWr),
    .stallPipe(stallPipe), .readData(readData), .respValid(respValid),
    .errOut(errOut), .hitCount(hitCount), .missCount(missCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        hit;
    int          done_at;
    int          err_at;
    logic        exp_err;
    int          exp_stall;
    int          exp_hit;
    int          exp_miss;
  } vec_t;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    logic [15:0] hit;
    logic [15:0] miss;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] hit_m = '0;
  logic [15:0] miss_m = '0;
  logic [15:0] rdata_m = '0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic err);
    exp_t e;
    e.err   = err;
    e.rdata = rdata_m;
    e.hit   = hit_m;
    e.miss  = miss_m;
    sb.push_back(e);
  endtask

  // Response monitor: every respValid pops one expected response.
  always @(negedge clk) begin
    if (rst && respValid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got respValid=1 expected no response");
      end else begin
        mon_e = sb.pop_front();
        check1("resp_err", errOut, mon_e.err);
        check16("resp_rdata", readData, mon_e.rdata);
        check16("resp_hit_count", hitCount, mon_e.hit);
        check16("resp_miss_count", missCount, mon_e.miss);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int c;
    @(negedge clk);
    exValid     = 1'b1;
    exMemRead   = v.rd;
    exMemWrite  = v.wr;
    exAddr      = v.addr;
    exWriteData = v.wdata;
    if (v.addr[0]) rdata_m = '0;
    else if (!v.exp_err && !v.wr) rdata_m = v.rdata;
    hit_m  = hit_m + 16'(v.exp_hit);
    miss_m = miss_m + 16'(v.exp_miss);
    push_exp(v.exp_err);
    c = 0;
    forever begin
      @(negedge clk);
      exValid    = 1'b0;
      exMemRead  = 1'b0;
      exMemWrite = 1'b0;
      if (respValid) break;
      if (c >= 64) begin
        checks++;
        errors++;
        $display("FAIL resp_wait: got no respValid after %0d cycles expected one", c);
        break;
      end
      check1("stall_busy", stallPipe, 1'b1);
      check1("mem_rd", memRd, (c == 0) && v.rd && !v.wr);
      check1("mem_wr", memWr, (c == 0) && v.wr);
      check16("mem_addr", memAddr, v.addr);
      check16("mem_wdata", memDataIn, v.wdata);
      memDone     = (c == v.done_at);
      memErr      = (c == v.err_at);
      memCacheHit = v.hit;
      memDataOut  = v.rdata;
      c++;
    end
    check1("resp_stall", stallPipe, 1'b0);
    check1("resp_rd", memRd, 1'b0);
    check1("resp_wr", memWr, 1'b0);
    checkint("stall_cycles", c, v.exp_stall);
    memDone     = 1'b0;
    memErr      = 1'b0;
    memCacheHit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    //              rd    wr    addr      wdata     rdata     hit  done err  xerr stall h  m
    vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1,  0, -1, 1'b0,  1, 1, 0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0,  4, -1, 1'b0,  5, 0, 1};
    vecs[2]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b0, -1, -1, 1'b1,  0, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h5A5A, 1'b0,  0, -1, 1'b0,  1, 0, 1};
    vecs[4]  = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1111, 1'b1,  2, -1, 1'b0,  3, 0, 1};
    vecs[5]  = '{1'b0, 1'b1, 16'h0300, 16'hABCD, 16'h9999, 1'b1,  0, -1, 1'b0,  1, 1, 0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h2222, 1'b1,  0,  0, 1'b1,  1, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0402, 16'h0000, 16'h3333, 1'b0, -1,  3, 1'b1,  4, 0, 0};
    vecs[8]  = '{1'b1, 1'b1, 16'h0500, 16'hCAFE, 16'h4444, 1'b0,  1, -1, 1'b0,  2, 0, 1};
    vecs[9]  = '{1'b1, 1'b0, 16'h0600, 16'h0000, 16'h5555, 1'b0, -1, -1, 1'b1, 32, 0, 0};
    vecs[10] = '{1'b1, 1'b0, 16'h0700, 16'h0000, 16'h6666, 1'b0, 31, -1, 1'b0, 32, 0, 1};
    vecs[11] = '{1'b0, 1'b1, 16'h0021, 16'h7777, 16'h0000, 1'b0, -1, -1, 1'b1,  0, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst_stall", stallPipe, 1'b0);
    check1("rst_resp", respValid, 1'b0);
    check1("rst_err", errOut, 1'b0);
    check1("rst_rd", memRd, 1'b0);
    check1("rst_wr", memWr, 1'b0);
    check16("rst_addr", memAddr, 16'h0000);
    check16("rst_wdata", memDataIn, 16'h0000);
    check16("rst_rdata", readData, 16'h0000);
    check16("rst_hit", hitCount, 16'h0000);
    check16("rst_miss", missCount, 16'h0000);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // exValid without read or write is ignored
    @(negedge clk);
    exValid = 1'b1;
    exAddr  = 16'h0040;
    repeat (3) begin
      @(negedge clk);
      check1("nop_stall", stallPipe, 1'b0);
      check1("nop_rd", memRd, 1'b0);
    end
    exValid = 1'b0;

    // Hit counter saturation with a back-to-back accept from RESP
    @(negedge clk);
    force dut.hit_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.hit_count_q;
    @(negedge clk);
    check16("hit_preload", hitCount, 16'hFFFE);
    exValid     = 1'b1;
    exMemRead   = 1'b1;
    exAddr      = 16'h0800;
    memDone     = 1'b1;
    memCacheHit = 1'b1;
    memDataOut  = 16'h7777;
    hit_m       = 16'hFFFF;
    rdata_m     = 16'h7777;
    push_exp(1'b0);
    @(negedge clk);
    check1("b2b_rd1", memRd, 1'b1);
    check1("b2b_stall1", stallPipe, 1'b1);
    exAddr = 16'h0802;
    @(negedge clk);
    check1("b2b_resp1", respValid, 1'b1);
    memDataOut = 16'h8888;
    rdata_m    = 16'h8888;
    push_exp(1'b0);
    @(negedge clk);
    check1("b2b_req_direct", stallPipe, 1'b1);
    check1("b2b_rd2", memRd, 1'b1);
    check16("b2b_addr2", memAddr, 16'h0802);
    exValid   = 1'b0;
    exMemRead = 1'b0;
    @(negedge clk);
    check1("b2b_resp2", respValid, 1'b1);
    check16("hit_saturated", hitCount, 16'hFFFF);
    memDone     = 1'b0;
    memCacheHit = 1'b0;

    // Reset in the middle of WAIT abandons the access
    @(negedge clk);
    exValid   = 1'b1;
    exMemRead = 1'b1;
    exAddr    = 16'h0900;
    @(negedge clk);
    exValid = 1'b0;
    repeat (3) @(negedge clk);
    check1("wait_stall", stallPipe, 1'b1);
    rst       = 1'b0;
    exValid   = 1'b1;
    exAddr    = 16'h0A00;
    #1;
    check1("arst_stall", stallPipe, 1'b0);
    check1("arst_resp", respValid, 1'b0);
    check16("arst_addr", memAddr, 16'h0000);
    check16("arst_hit", hitCount, 16'h0000);
    check16("arst_miss", missCount, 16'h0000);
    check16("arst_rdata", readData, 16'h0000);
    @(posedge clk);
    #1;
    check1("rst_no_accept", stallPipe, 1'b0);
    @(negedge clk);
    rst       = 1'b1;
    exValid   = 1'b0;
    exMemRead = 1'b0;
    memDone   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check1("late_done_resp", respValid, 1'b0);
      check1("late_done_stall", stallPipe, 1'b0);
    end
    memDone = 1'b0;

    @(negedge clk);
    checkint("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
